ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the pipelined RV32I core.
- Consumes the 5-bit ALU control code produced by decode, together with the operands from the ID/EX boundary.
- Computes the ALU result, branch/jump resolution and target, then registers everything into the EX/MEM boundary.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, value driven on ex_pc during reset

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ID/EX slot holds a real instruction
- stall  in  1  hold EX/MEM registers unchanged
- flush  in  1  load bubble into EX/MEM
- pc  in  XLEN  PC of instruction
- inst  in  32  raw instruction word
- rs1_data  in  XLEN  register-file operand A
- rs2_data  in  XLEN  register-file operand B / store data
- imm  in  XLEN  sign-extended immediate
- alu_src_imm  in  1  1 selects imm as ALU operand B
- regwrite  in  1  instruction writes rd
- alu_ctrl  in  5  ALU operation code
- ex_valid  out  1  EX/MEM slot valid
- ex_result  out  XLEN  ALU result, or pc+4 for JAL/JALR
- ex_store_data  out  XLEN  rs2 value for stores
- ex_rd  out  5  destination register, inst[11:7]
- ex_regwrite  out  1  registered write enable
- ex_inst  out  32  registered instruction
- ex_pc  out  XLEN  registered PC
- branch_taken  out  1  redirect fetch
- branch_target  out  XLEN  redirect address
- illegal_op  out  1  alu_ctrl was 5'b11111 on a valid instruction

Behaviour:
- ALU code map:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 SLL, 00100 SLTU
  - 00101 XOR, 00110 SUB, 00111 SRL, 01000 SLT (signed), 01001 SRA
  - 01010 pass operand B (LUI)
  - 11111 invalid
  - any other code: result 0, not flagged illegal.
- Operand A = rs1_data. Operand B = alu_src_imm ? imm : rs2_data.
- Shifts use B[4:0]. SLT/SLTU produce 0/1 zero-extended. All arithmetic wraps modulo 2^XLEN.
- JAL (opcode 1101111) and JALR (1100111): result = pc+4, taken = 1.
  - JAL target = pc+imm.
  - JALR target = (rs1_data+imm) & ~1.
- Branch (1100011): target = pc+imm. Taken is determined by inst[14:12]:
  - BEQ: SUB result == 0
  - BNE: SUB result != 0
  - BLT: SLT == 1
  - BGE: SLT == 0
  - BLTU: SLTU == 1
  - BGEU: SLTU == 0
  - other funct3: not taken.
- All outputs are registered. Latency is 1 cycle, from inputs at edge N to outputs after edge N.
- Update priority at each rising clk edge: rst > flush > stall > load.
- rst:
  - All outputs 0.
  - ex_pc = RESET_PC.
  - ex_inst = 32'h0000_0013 (NOP).
- flush:
  - Same values as rst, including with stall asserted: flush wins.
- stall (no flush):
  - Every output register holds its value, including branch_taken.
  - The inputs are ignored.
- load, in_valid=0:
  - ex_valid, ex_regwrite, branch_taken and illegal_op = 0.
  - The other outputs capture their inputs.
- load, in_valid=1 and alu_ctrl=11111:
  - ex_valid=1, illegal_op=1.
  - ex_regwrite=0, branch_taken=0.
- load, otherwise:
  - ex_valid=1, ex_regwrite=regwrite, illegal_op=0, branch fields as computed.
- ex_regwrite is forced to 0 when inst[11:7]=0.
- branch_taken is a level for exactly the cycles the slot holds a taken instruction. The hazard unit is responsible for asserting flush upstream.

Optional Feature:
- Macro: EX_FWD_EN.
- When defined, an EX→EX bypass is added:
  - If ex_valid & ex_regwrite & ex_rd!=0 & ex_rd==inst[19:15], operand A uses ex_result instead of rs1_data.
  - Likewise inst[24:20] for rs2, which affects both operand B (when alu_src_imm=0) and store data.
  - The bypass is disabled while stall is asserted.
- When undefined, the operands come straight from the ports and no comparators exist.

Test Plan:
- Reset: assert rst 2 cycles → ex_valid=0, branch_taken=0, ex_inst=32'h00000013, ex_pc=0.
- ADD/SUB/SRA: rs1=32'h8000_0000, rs2=4.
  - alu_ctrl=00010 → ex_result=32'h8000_0004.
  - alu_ctrl=00110 → 32'h7FFF_FFFC.
  - alu_ctrl=01001 → 32'hF800_0000.
- BLT: rs1=-1, rs2=1, pc=32'h100, imm=32'h20 → branch_taken=1, target=32'h120.
  - Same with BLTU → branch_taken=0.
- JALR: rs1=32'h1003, imm=4, pc=32'h40 → target=32'h1006, ex_result=32'h44, branch_taken=1.
- Stall/flush:
  - Load ADD, then stall 3 cycles with changing inputs → outputs frozen.
  - Assert stall+flush together → ex_valid=0 next edge.
- Illegal and forwarding:
  - alu_ctrl=11111, in_valid=1 → illegal_op=1, ex_regwrite=0.
  - With EX_FWD_EN: addi x5,x0,7 then add x6,x5,x5 (rs1_data=0) → ex_result=14.
  - Without EX_FWD_EN: the same sequence → ex_result=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ALU, branch/jump resolution and the EX/MEM register.
// Define EX_FWD_EN to add the EX->EX operand bypass from the EX/MEM register.
module ex_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src_imm,
    input  logic            regwrite,
    input  logic [4:0]      alu_ctrl,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_pc,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            illegal_op
);
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    logic            ex_valid_q, ex_regwrite_q, branch_taken_q, illegal_op_q;
    logic [XLEN-1:0] ex_result_q, ex_store_data_q, ex_pc_q, branch_target_q;
    logic [4:0]      ex_rd_q;
    logic [31:0]     ex_inst_q;

    logic            ex_valid_d, ex_regwrite_d, branch_taken_d, illegal_op_d;
    logic [XLEN-1:0] ex_result_d, branch_target_d;

    logic [XLEN-1:0] op_a, rs2_val, op_b, alu_res, sub_res;
    logic [4:0]      shamt;
    logic            lt_s, lt_u, br_cond, is_jal, is_jalr, is_branch;

`ifdef EX_FWD_EN
    // Bypass is suppressed during stall: the held EX/MEM slot is not the producer of the held ID/EX slot.
    logic fwd_ok, fwd_a, fwd_b;
    assign fwd_ok  = !stall && ex_valid_q && ex_regwrite_q && (ex_rd_q != 5'd0);
    assign fwd_a   = fwd_ok && (ex_rd_q == inst[19:15]);
    assign fwd_b   = fwd_ok && (ex_rd_q == inst[24:20]);
    assign op_a    = fwd_a ? ex_result_q : rs1_data;
    assign rs2_val = fwd_b ? ex_result_q : rs2_data;
`else
    assign op_a    = rs1_data;
    assign rs2_val = rs2_data;
`endif

    assign op_b    = alu_src_imm ? imm : rs2_val;
    assign shamt   = op_b[4:0];
    assign sub_res = op_a - op_b;
    assign lt_s    = $signed(op_a) < $signed(op_b);
    assign lt_u    = op_a < op_b;

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            5'b00000: alu_res = op_a & op_b;
            5'b00001: alu_res = op_a | op_b;
            5'b00010: alu_res = op_a + op_b;
            5'b00011: alu_res = op_a << shamt;
            5'b00100: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            5'b00101: alu_res = op_a ^ op_b;
            5'b00110: alu_res = sub_res;
            5'b00111: alu_res = op_a >> shamt;
            5'b01000: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            5'b01001: alu_res = $unsigned($signed(op_a) >>> shamt);
            5'b01010: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    assign is_jal    = (inst[6:0] == OPC_JAL);
    assign is_jalr   = (inst[6:0] == OPC_JALR);
    assign is_branch = (inst[6:0] == OPC_BRANCH);

    always_comb begin
        br_cond = 1'b0;
        case (inst[14:12])
            3'b000:  br_cond = (sub_res == '0);
            3'b001:  br_cond = (sub_res != '0);
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        illegal_op_d    = in_valid && (alu_ctrl == 5'b11111);
        ex_valid_d      = in_valid;
        ex_regwrite_d   = in_valid && !illegal_op_d && regwrite && (inst[11:7] != 5'd0);
        branch_taken_d  = in_valid && !illegal_op_d && (is_jal || is_jalr || (is_branch && br_cond));
        ex_result_d     = (is_jal || is_jalr) ? (pc + XLEN'(4)) : alu_res;
        branch_target_d = is_jalr ? ((op_a + imm) & {{(XLEN-1){1'b1}}, 1'b0}) : (pc + imm);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid_q      <= 1'b0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= 5'd0;
            ex_regwrite_q   <= 1'b0;
            ex_inst_q       <= NOP_INST;
            ex_pc_q         <= RESET_PC;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            illegal_op_q    <= 1'b0;
        end else if (!stall) begin
            ex_valid_q      <= ex_valid_d;
            ex_result_q     <= ex_result_d;
            ex_store_data_q <= rs2_val;
            ex_rd_q         <= inst[11:7];
            ex_regwrite_q   <= ex_regwrite_d;
            ex_inst_q       <= inst;
            ex_pc_q         <= pc;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            illegal_op_q    <= illegal_op_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_rd         = ex_rd_q;
    assign ex_regwrite   = ex_regwrite_q;
    assign ex_inst       = ex_inst_q;
    assign ex_pc         = ex_pc_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign illegal_op    = illegal_op_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed test-plan cases plus random traffic against a reference model,
// with a per-cycle scoreboard comparing the whole EX/MEM register.
module tb_ex_stage;
    typedef struct packed {
        logic        rst;
        logic        in_valid;
        logic        stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        src_imm;
        logic        regwrite;
        logic [4:0]  alu_ctrl;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        regwrite;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, alu_src_imm, regwrite;
    logic [31:0] pc, inst, rs1_data, rs2_data, imm;
    logic [4:0]  alu_ctrl;
    logic        ex_valid, ex_regwrite, branch_taken, illegal_op;
    logic [31:0] ex_result, ex_store_data, ex_inst, ex_pc, branch_target;
    logic [4:0]  ex_rd;

    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];
    out_t cur;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .pc(pc), .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_src_imm(alu_src_imm), .regwrite(regwrite), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .branch_taken(branch_taken), .branch_target(branch_target), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic out_t reset_out();
        out_t o;
        o        = '0;
        o.inst   = 32'h0000_0013;
        return o;
    endfunction

    // Reference model of the slot contents after one edge, stated directly from the ISA rules.
    function automatic out_t model(out_t c, in_t x);
        out_t        o;
        logic [31:0] a, s, b, alu;
        logic [6:0]  opc;
        logic        t, ill;
        if (x.rst || x.flush) return reset_out();
        if (x.stall) return c;
        a = x.rs1;
        s = x.rs2;
`ifdef EX_FWD_EN
        if (c.valid && c.regwrite && c.rd != 5'd0) begin
            if (c.rd == x.inst[19:15]) a = c.result;
            if (c.rd == x.inst[24:20]) s = c.result;
        end
`endif
        b = x.src_imm ? x.imm : s;
        case (x.alu_ctrl)
            5'd0:    alu = a & b;
            5'd1:    alu = a | b;
            5'd2:    alu = a + b;
            5'd3:    alu = a << b[4:0];
            5'd4:    alu = (a < b) ? 32'd1 : 32'd0;
            5'd5:    alu = a ^ b;
            5'd6:    alu = a - b;
            5'd7:    alu = a >> b[4:0];
            5'd8:    alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:    alu = $unsigned($signed(a) >>> b[4:0]);
            5'd10:   alu = b;
            default: alu = 32'd0;
        endcase
        opc = x.inst[6:0];
        t   = 1'b0;
        if (opc == 7'b1101111 || opc == 7'b1100111) t = 1'b1;
        else if (opc == 7'b1100011) begin
            case (x.inst[14:12])
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = ($signed(a) >= $signed(b));
                3'd6: t = (a < b);
                3'd7: t = (a >= b);
                default: t = 1'b0;
            endcase
        end
        ill        = x.in_valid && (x.alu_ctrl == 5'd31);
        o.valid    = x.in_valid;
        o.result   = (opc == 7'b1101111 || opc == 7'b1100111) ? x.pc + 32'd4 : alu;
        o.store    = s;
        o.rd       = x.inst[11:7];
        o.regwrite = x.in_valid && !ill && x.regwrite && (x.inst[11:7] != 5'd0);
        o.inst     = x.inst;
        o.pc       = x.pc;
        o.taken    = x.in_valid && !ill && t;
        o.target   = (opc == 7'b1100111) ? ((a + x.imm) / 2) * 2 : x.pc + x.imm;
        o.illegal  = ill;
        return o;
    endfunction

    // Drive one ID/EX slot and record the expected EX/MEM contents after the next edge.
    task automatic apply(in_t x);
        rst = x.rst; in_valid = x.in_valid; stall = x.stall; flush = x.flush;
        pc = x.pc; inst = x.inst; rs1_data = x.rs1; rs2_data = x.rs2; imm = x.imm;
        alu_src_imm = x.src_imm; regwrite = x.regwrite; alu_ctrl = x.alu_ctrl;
        cur = model(cur, x);
        exp_q.push_back(cur);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ex_valid, ex_result, ex_store_data, ex_rd, ex_regwrite, ex_inst, ex_pc,
                  branch_taken, branch_target, illegal_op};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL slot @%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    function automatic in_t idle();
        in_t x;
        x      = '0;
        x.inst = 32'h0000_0013;
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t         x;
        logic [6:0]  opcs [7];
        opcs = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0100011};
        x          = '0;
        x.rst      = ($urandom_range(0, 59) == 0);
        x.flush    = ($urandom_range(0, 19) == 0);
        x.stall    = ($urandom_range(0, 7) == 0);
        x.in_valid = ($urandom_range(0, 5) != 0);
        x.pc       = $urandom & 32'hFFFF_FFFC;
        x.inst     = $urandom;
        x.inst[6:0]   = opcs[$urandom_range(0, 6)];
        x.inst[11:7]  = 5'($urandom_range(0, 7));
        x.inst[19:15] = 5'($urandom_range(0, 7));
        x.inst[24:20] = 5'($urandom_range(0, 7));
        x.rs1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        x.rs2      = ($urandom_range(0, 3) == 0) ? x.rs1 : $urandom;
        x.imm      = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
        x.src_imm  = $urandom_range(0, 1) == 1;
        x.regwrite = $urandom_range(0, 3) != 0;
        x.alu_ctrl = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 12));
        return x;
    endfunction

    initial begin
        in_t x;
        int  waited;
        cur = reset_out();
        x   = idle();
        x.rst = 1'b1;
        apply(x);
        tick(); apply(x);
        tick();
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset branch_taken", 32'(branch_taken), 32'd0);
        check("reset ex_inst", ex_inst, 32'h0000_0013);
        check("reset ex_pc", ex_pc, 32'd0);

        // ADD / SUB / SRA on rs1=0x80000000, rs2=4
        x = idle();
        x.in_valid = 1'b1; x.inst = 32'h0020_81B3; x.rs1 = 32'h8000_0000; x.rs2 = 32'd4;
        x.regwrite = 1'b1; x.alu_ctrl = 5'b00010;
        apply(x); tick();
        check("add", ex_result, 32'h8000_0004);
        x.alu_ctrl = 5'b00110; apply(x); tick();
        check("sub", ex_result, 32'h7FFF_FFFC);
        x.alu_ctrl = 5'b01001; apply(x); tick();
        check("sra", ex_result, 32'hF800_0000);

        // BLT then BLTU with rs1=-1, rs2=1
        x = idle();
        x.in_valid = 1'b1; x.inst = {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
        x.rs1 = 32'hFFFF_FFFF; x.rs2 = 32'd1; x.pc = 32'h100; x.imm = 32'h20; x.alu_ctrl = 5'b00110;
        apply(x); tick();
        check("blt taken", 32'(branch_taken), 32'd1);
        check("blt target", branch_target, 32'h120);
        x.inst[14:12] = 3'b110; apply(x); tick();
        check("bltu taken", 32'(branch_taken), 32'd0);

        // JALR
        x = idle();
        x.in_valid = 1'b1; x.inst = {12'd4, 5'd2, 3'b000, 5'd1, 7'b1100111};
        x.rs1 = 32'h1003; x.imm = 32'd4; x.pc = 32'h40; x.src_imm = 1'b1; x.regwrite = 1'b1;
        x.alu_ctrl = 5'b00010;
        apply(x); tick();
        check("jalr target", branch_target, 32'h1006);
        check("jalr result", ex_result, 32'h44);
        check("jalr taken", 32'(branch_taken), 32'd1);

        // Stall holds the loaded ADD for three cycles
        x = idle();
        x.in_valid = 1'b1; x.inst = 32'h0020_81B3; x.rs1 = 32'h8000_0000; x.rs2 = 32'd4;
        x.regwrite = 1'b1; x.alu_ctrl = 5'b00010;
        apply(x); tick();
        for (int i = 0; i < 3; i++) begin
            x = rand_in();
            x.rst = 1'b0; x.flush = 1'b0; x.stall = 1'b1;
            apply(x); tick();
            check("stall result", ex_result, 32'h8000_0004);
            check("stall valid", 32'(ex_valid), 32'd1);
        end
        x.stall = 1'b1; x.flush = 1'b1; apply(x); tick();
        check("flush+stall valid", 32'(ex_valid), 32'd0);
        check("flush+stall inst", ex_inst, 32'h0000_0013);

        // Illegal code on a valid slot
        x = idle();
        x.in_valid = 1'b1; x.inst = 32'h0020_81B3; x.regwrite = 1'b1; x.alu_ctrl = 5'b11111;
        apply(x); tick();
        check("illegal flag", 32'(illegal_op), 32'd1);
        check("illegal regwrite", 32'(ex_regwrite), 32'd0);

        // addi x5,x0,7 ; add x6,x5,x5 with stale register-file operands of 0
        x = idle();
        x.in_valid = 1'b1; x.inst = 32'h0070_0293; x.imm = 32'd7; x.src_imm = 1'b1;
        x.regwrite = 1'b1; x.alu_ctrl = 5'b00010;
        apply(x); tick();
        x.inst = 32'h0052_8333; x.imm = 32'd0; x.src_imm = 1'b0;
        apply(x); tick();
`ifdef EX_FWD_EN
        check("fwd add", ex_result, 32'd14);
`else
        check("nofwd add", ex_result, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            apply(rand_in());
            tick();
        end
        apply(idle());

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            tick();
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
